// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: fetch PC, direct-mapped one-word-line icache with MC fill,
// 2-bit BHT for B-type prediction, and a circular instruction queue toward the dispatcher.
module inst_fetch_queue #(
  parameter int ICIDX  = 8,
  parameter int BHTIDX = 6,
  parameter int QLOG   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic [31:0] jump_rel_pc,
  input  logic        br_upd_flag,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken,
  input  logic        inst_MC_flag,
  input  logic [31:0] inst_MC,
  output logic        inst_MC_req,
  output logic [31:0] inst_MC_addr,
  input  logic        ID_ready,
  output logic        inst_ID_flag,
  output logic [31:0] inst_ID,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_prd_pc
);

  localparam int ICN  = 2 ** ICIDX;
  localparam int BHTN = 2 ** BHTIDX;
  localparam int QN   = 2 ** QLOG;
  localparam int TAGW = 30 - ICIDX;
  localparam logic [QLOG:0] PTR_ONE   = 1;
  localparam logic [6:0]    OP_JAL    = 7'b1101111;
  localparam logic [6:0]    OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} mc_state_e;

  mc_state_e        state_q;
  logic [31:0]      pc_q;
  logic [ICN-1:0]   ic_valid_q;
  logic [TAGW-1:0]  ic_tag_q  [ICN];
  logic [31:0]      ic_data_q [ICN];
  logic [1:0]       bht_q     [BHTN];
  logic [31:0]      q_inst_q  [QN];
  logic [31:0]      q_pc_q    [QN];
  logic [31:0]      q_prd_q   [QN];
  logic [QLOG:0]    rd_ptr_q, wr_ptr_q;

  logic [ICIDX-1:0]  ic_idx;
  logic [TAGW-1:0]   ic_tag;
  logic [BHTIDX-1:0] bht_idx, upd_idx;
  logic [QLOG-1:0]   wr_idx, rd_idx;
  logic              run, hit, mc_accept, fetch_vld;
  logic              q_empty, q_full;
  logic              push, pop, fill, issue;
  logic [31:0]       fetch_word, pred_pc;
  logic              unused_upd_bits;

  function automatic logic [31:0] predict_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic bht_taken);
    logic [31:0] j_imm, b_imm, nxt;
    j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    nxt   = pc + 32'd4;
    if (ins[6:0] == OP_JAL)
      nxt = pc + j_imm;
    else if (ins[6:0] == OP_BRANCH && bht_taken)
      nxt = pc + b_imm;
    return nxt;
  endfunction

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  assign ic_idx  = pc_q[ICIDX+1:2];
  assign ic_tag  = pc_q[31:ICIDX+2];
  assign bht_idx = pc_q[BHTIDX+1:2];
  assign upd_idx = br_upd_pc[BHTIDX+1:2];
  assign wr_idx  = wr_ptr_q[QLOG-1:0];
  assign rd_idx  = rd_ptr_q[QLOG-1:0];
  assign unused_upd_bits = ^{br_upd_pc[31:BHTIDX+2], br_upd_pc[1:0]};

  assign run       = rst && rdy;
  assign hit       = ic_valid_q[ic_idx] && (ic_tag_q[ic_idx] == ic_tag);
  // Responses only count while a request is live; in DROP the stale word is ignored.
  assign mc_accept = (state_q == S_WAIT) && inst_MC_flag;
  assign fetch_vld = hit || mc_accept;
  assign fetch_word = hit ? ic_data_q[ic_idx] : inst_MC;
  assign pred_pc   = predict_next(pc_q, fetch_word, bht_q[bht_idx][1]);

  assign q_empty = (rd_ptr_q == wr_ptr_q);
  assign q_full  = (rd_ptr_q[QLOG] != wr_ptr_q[QLOG]) && (rd_idx == wr_idx);

  // Full is taken from the start of the cycle, so a same-cycle pop never frees room for a push.
  assign push  = run && fetch_vld && !q_full && !jump_wrong;
  assign pop   = run && !q_empty && ID_ready && !jump_wrong;
  assign fill  = run && mc_accept;
  assign issue = run && (state_q == S_IDLE) && !hit && !q_full && !jump_wrong;

  assign inst_MC_req  = (state_q == S_WAIT) || issue;
  assign inst_MC_addr = pc_q;

  assign inst_ID_flag = !q_empty;
  assign inst_ID      = q_empty ? '0 : q_inst_q[rd_idx];
  assign inst_pc      = q_empty ? '0 : q_pc_q[rd_idx];
  assign inst_prd_pc  = q_empty ? '0 : q_prd_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ic_valid_q <= '0;
      state_q    <= S_IDLE;
      for (int i = 0; i < BHTN; i++)
        bht_q[i] <= 2'b01;
    end else if (rdy) begin
      if (jump_wrong) begin
        pc_q     <= jump_rel_pc;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          pc_q     <= pred_pc;
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (fill)
        ic_valid_q[ic_idx] <= 1'b1;
      if (br_upd_flag)
        bht_q[upd_idx] <= ctr_update(bht_q[upd_idx], br_upd_taken);
      case (state_q)
        S_IDLE:  if (issue) state_q <= S_WAIT;
        S_WAIT: begin
          if (inst_MC_flag)    state_q <= S_IDLE;
          else if (jump_wrong) state_q <= S_DROP;
        end
        S_DROP:  if (inst_MC_flag) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      ic_tag_q[ic_idx]  <= ic_tag;
      ic_data_q[ic_idx] <= inst_MC;
    end
    if (push) begin
      q_inst_q[wr_idx] <= fetch_word;
      q_pc_q[wr_idx]   <= pc_q;
      q_prd_q[wr_idx]  <= pred_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a small memory-controller model answers fetch
// requests with a programmable latency while the main sequence checks queue and request outputs.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, br_upd_flag, br_upd_taken, inst_MC_flag, ID_ready;
  logic [31:0] jump_rel_pc, br_upd_pc, inst_MC;
  logic        inst_MC_req, inst_ID_flag;
  logic [31:0] inst_MC_addr, inst_ID, inst_pc, inst_prd_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  int          mc_lat = 1;
  bit          pend   = 1'b0;
  logic [31:0] paddr  = '0;
  int          pcnt   = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'h0200_006F;
  localparam logic [31:0] BEQ  = 32'hFE00_0CE3;
  localparam logic [31:0] ADD5 = 32'h0050_0093;
  localparam logic [31:0] ADD7 = 32'h0070_0113;

  inst_fetch_queue #(.ICIDX(8), .BHTIDX(6), .QLOG(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong), .jump_rel_pc(jump_rel_pc),
    .br_upd_flag(br_upd_flag), .br_upd_pc(br_upd_pc), .br_upd_taken(br_upd_taken),
    .inst_MC_flag(inst_MC_flag), .inst_MC(inst_MC), .inst_MC_req(inst_MC_req),
    .inst_MC_addr(inst_MC_addr), .ID_ready(ID_ready), .inst_ID_flag(inst_ID_flag),
    .inst_ID(inst_ID), .inst_pc(inst_pc), .inst_prd_pc(inst_prd_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: settled outputs; the memory model latches a new request here.
  task automatic neg();
    @(negedge clk);
    if (inst_MC_req && !pend && !inst_MC_flag) begin
      pend  = 1'b1;
      paddr = inst_MC_addr;
      pcnt  = mc_lat;
    end
  endtask

  // Just after the edge: the memory model raises its one-cycle response pulse.
  task automatic pos();
    @(posedge clk);
    #1;
    inst_MC_flag = 1'b0;
    if (pend) begin
      if (pcnt <= 1) begin
        inst_MC_flag = 1'b1;
        inst_MC      = mem[paddr[9:2]];
        pend         = 1'b0;
      end else begin
        pcnt--;
      end
    end
  endtask

  task automatic wait_head(input logic [31:0] tgt, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      pos();
      neg();
      if (inst_ID_flag && inst_pc == tgt) found = 1'b1;
    end
    total++;
    assert (found === 1'b1) else begin
      bad++;
      $error("FAIL %s timeout head_pc=%h expected=%h", tag, inst_pc, tgt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[4]  = JAL;   // 0x10: jal +0x20
    mem[16] = BEQ;   // 0x40: beq -8
    mem[32] = ADD5;  // 0x80
    mem[64] = ADD7;  // 0x100
    rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0; jump_rel_pc = '0;
    br_upd_flag = 1'b0; br_upd_pc = '0; br_upd_taken = 1'b0;
    inst_MC_flag = 1'b0; inst_MC = '0; ID_ready = 1'b1;

    // reset
    pos(); pos(); neg();
    chk("rst_flag", inst_ID_flag, 0);
    chk("rst_req", inst_MC_req, 0);
    chk("rst_addr", inst_MC_addr, 0);
    chk("rst_id", inst_ID, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_prd", inst_prd_pc, 0);

    // preload 0x0..0xC through the miss path
    pos(); rst = 1'b1; neg();
    chk("miss_req0", inst_MC_req, 1);
    chk("miss_addr0", inst_MC_addr, 32'h0);
    chk("miss_flag0", inst_ID_flag, 0);
    pos(); neg();
    chk("miss_wait_req", inst_MC_req, 1);
    chk("miss_wait_flag", inst_ID_flag, 0);
    pos(); neg();
    chk("miss_head_flag", inst_ID_flag, 1);
    chk("miss_head_pc", inst_pc, 32'h0);
    chk("miss_head_id", inst_ID, NOP);
    chk("miss_head_prd", inst_prd_pc, 32'h4);
    chk("miss_next_addr", inst_MC_addr, 32'h4);
    repeat (5) begin pos(); neg(); end
    pos(); jump_wrong = 1'b1; jump_rel_pc = 32'h0; neg();
    chk("pre_flush_pc", inst_pc, 32'hC);
    chk("flush_no_req", inst_MC_req, 0);
    pos(); jump_wrong = 1'b0; neg();
    chk("post_flush_empty", inst_ID_flag, 0);
    chk("hit_no_req", inst_MC_req, 0);
    for (int k = 0; k < 4; k++) begin
      pos(); neg();
      chk("hit_flag", inst_ID_flag, 1);
      chk("hit_pc", inst_pc, 32'(4 * k));
      chk("hit_prd", inst_prd_pc, 32'(4 * k + 4));
      chk("hit_id", inst_ID, NOP);
    end
    chk("jal_req", inst_MC_req, 1);
    chk("jal_addr", inst_MC_addr, 32'h10);

    // JAL prediction
    pos(); neg();
    chk("jal_wait_empty", inst_ID_flag, 0);
    pos(); neg();
    chk("jal_pc", inst_pc, 32'h10);
    chk("jal_id", inst_ID, JAL);
    chk("jal_prd", inst_prd_pc, 32'h30);
    chk("jal_next_addr", inst_MC_addr, 32'h30);
    chk("jal_next_req", inst_MC_req, 1);

    // BHT trained taken twice
    pos(); br_upd_flag = 1'b1; br_upd_pc = 32'h40; br_upd_taken = 1'b1; neg();
    pos(); neg();
    pos(); br_upd_flag = 1'b0; neg();
    wait_head(32'h40, 40, "beq_taken_wait");
    chk("beq_taken_id", inst_ID, BEQ);
    chk("beq_taken_prd", inst_prd_pc, 32'h38);

    // trained not-taken twice, then a same-cycle update/lookup uses the old counter
    pos(); br_upd_flag = 1'b1; br_upd_taken = 1'b0; neg();
    pos(); neg();
    pos(); br_upd_flag = 1'b0; jump_wrong = 1'b1; jump_rel_pc = 32'h40; neg();
    pos(); jump_wrong = 1'b0; br_upd_flag = 1'b1; br_upd_taken = 1'b1; neg();
    chk("beq_nt_hit_req", inst_MC_req, 0);
    pos(); br_upd_flag = 1'b0; neg();
    chk("beq_nt_pc", inst_pc, 32'h40);
    chk("beq_nt_prd", inst_prd_pc, 32'h44);

    // full queue on a miss stream at 0x200
    pos(); jump_wrong = 1'b1; jump_rel_pc = 32'h200; ID_ready = 1'b0; neg();
    pos(); jump_wrong = 1'b0; neg();
    chk("full_first_addr", inst_MC_addr, 32'h200);
    repeat (15) begin pos(); neg(); end
    for (int k = 0; k < 4; k++) begin
      pos(); neg();
      chk("full_req", inst_MC_req, 0);
      chk("full_addr", inst_MC_addr, 32'h220);
    end
    chk("full_head_flag", inst_ID_flag, 1);
    chk("full_head_pc", inst_pc, 32'h200);
    pos(); ID_ready = 1'b1; neg();
    chk("full_pop_req", inst_MC_req, 0);
    pos(); ID_ready = 1'b0; neg();
    chk("resume_head", inst_pc, 32'h204);
    chk("resume_req", inst_MC_req, 1);
    chk("resume_addr", inst_MC_addr, 32'h220);
    pos(); neg();
    for (int k = 0; k < 8; k++) begin
      pos(); if (k == 0) ID_ready = 1'b1; neg();
      chk("drain_flag", inst_ID_flag, 1);
      chk("drain_pc", inst_pc, 32'h204 + 32'(4 * k));
    end

    // flush while a miss is outstanding
    pos(); jump_wrong = 1'b1; jump_rel_pc = 32'h80; mc_lat = 3; neg();
    pos(); jump_wrong = 1'b0; neg();
    chk("drop_req", inst_MC_req, 1);
    chk("drop_addr", inst_MC_addr, 32'h80);
    pos(); jump_wrong = 1'b1; jump_rel_pc = 32'h100; neg();
    chk("drop_wait_addr", inst_MC_addr, 32'h80);
    pos(); jump_wrong = 1'b0; neg();
    chk("drop_state_req", inst_MC_req, 0);
    chk("drop_state_flag", inst_ID_flag, 0);
    chk("drop_state_addr", inst_MC_addr, 32'h100);
    pos(); neg();
    chk("drop_resp_req", inst_MC_req, 0);
    chk("drop_resp_flag", inst_ID_flag, 0);
    pos(); neg();
    chk("reissue_req", inst_MC_req, 1);
    chk("reissue_addr", inst_MC_addr, 32'h100);
    chk("reissue_flag", inst_ID_flag, 0);
    pos(); mc_lat = 1; neg();
    pos(); neg();
    pos(); neg();
    pos(); neg();
    chk("redir_flag", inst_ID_flag, 1);
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_id", inst_ID, ADD7);
    chk("redir_prd", inst_prd_pc, 32'h104);
    pos(); jump_wrong = 1'b1; jump_rel_pc = 32'h80; neg();
    pos(); jump_wrong = 1'b0; neg();
    chk("dropped_not_filled_req", inst_MC_req, 1);
    chk("dropped_not_filled_addr", inst_MC_addr, 32'h80);
    pos(); neg();

    // rdy low for three cycles during a hit stream
    pos(); jump_wrong = 1'b1; jump_rel_pc = 32'h0; neg();
    pos(); jump_wrong = 1'b0; neg();
    pos(); neg();
    for (int k = 0; k < 3; k++) begin
      pos(); if (k == 0) rdy = 1'b0; neg();
      chk("stall_flag", inst_ID_flag, 1);
      chk("stall_pc", inst_pc, 32'h4);
      chk("stall_addr", inst_MC_addr, 32'h8);
      chk("stall_req", inst_MC_req, 0);
    end
    pos(); rdy = 1'b1; neg();
    chk("unstall_pc", inst_pc, 32'h4);
    pos(); neg();
    chk("unstall_next_pc", inst_pc, 32'h8);
    chk("unstall_next_prd", inst_prd_pc, 32'hC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised next-generation instruction fetch stage. It owns the fetch PC, a direct-mapped instruction cache with a real fill path, a 2-bit-counter branch history table for B-type prediction, and an instruction queue that decouples fetch from the dispatcher. It sits between the memory controller (instruction port) and the dispatcher, and is redirected by the ROB on misprediction.

## Interface
- `ICIDX`, 8: icache index bits; `2**ICIDX` one-word lines.
- `BHTIDX`, 6: BHT index bits; `2**BHTIDX` 2-bit counters.
- `QLOG`, 3: queue depth `2**QLOG` entries (≥1).
- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: synchronous, active-low reset.
- `rdy` input 1: global enable; when low, all state holds.
- `jump_wrong` input 1: redirect/flush request from ROB.
- `jump_rel_pc` input 32: redirect target.
- `br_upd_flag` input 1: BHT training strobe.
- `br_upd_pc` input 32: PC of the resolved branch.
- `br_upd_taken` input 1: resolved direction.
- `inst_MC_flag` input 1: one-cycle pulse; `inst_MC` is valid.
- `inst_MC` input 32: fetched word.
- `inst_MC_req` output 1: fetch request level.
- `inst_MC_addr` output 32: fetch address.
- `ID_ready` input 1: dispatcher accepts the head entry this cycle.
- `inst_ID_flag` output 1: queue non-empty (head valid).
- `inst_ID` output 32: head instruction.
- `inst_pc` output 32: head PC.
- `inst_prd_pc` output 32: head predicted next PC.

## Operation
- Address split: index `pc[ICIDX+1:2]`, tag `pc[31:ICIDX+2]`. BHT index `pc[BHTIDX+1:2]`.
- `hit` = valid[idx] and tag match. The fetch word is the cache line on a hit, otherwise `inst_MC` when `inst_MC_flag` is high and the response is not being dropped.
- A word is available when (`hit` or accepted MC response). It is enqueued when the queue is not full and `jump_wrong` is low.
- Prediction at enqueue:
  - J-type (`1101111`): J-immediate `{{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}`; predicted PC = pc+imm.
  - B-type (`1100011`): if counter[1] is set, predicted PC = pc + B-immediate `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}`; otherwise pc+4.
  - All other opcodes, including JALR: pc+4.
  - `pc` takes the predicted PC. All arithmetic is 32-bit modulo.
- Cache fill: an accepted MC response writes data, tag and valid at its address, even if the queue is full in that cycle. In that case the next cycle hits.
- MC request FSM:
  - States: IDLE, WAIT, DROP.
  - IDLE → WAIT when a miss occurs and the queue is not full. `inst_MC_req`=1 and `inst_MC_addr`=pc are driven in WAIT and in the IDLE cycle that issues.
  - WAIT → IDLE on `inst_MC_flag`.
  - `jump_wrong` during WAIT without a same-cycle flag → DROP. In DROP the request is deasserted; the next `inst_MC_flag` is discarded (no fill, no enqueue), then → IDLE.
  - Exactly one request is outstanding at a time. Address stays stable while in WAIT.
- BHT: on `br_upd_flag`, the saturating 2-bit counter is incremented if taken, else decremented. Counters reset to 01 (weakly not-taken). An update and a same-index lookup in the same cycle use the old value.
- Queue: circular buffer with `QLOG`+1-bit read/write pointers; full when the MSBs differ and the LSBs are equal. Pop when `inst_ID_flag` and `ID_ready`. Push and pop in the same cycle are allowed, including when full (pop frees space for the same-cycle push only if the implementation computes full after the pop; required: push is blocked when full at the start of the cycle).
- `jump_wrong`: pointers cleared (queue empty next cycle), `pc` ← `jump_rel_pc`, no enqueue or pop that cycle, FSM per above. Cache and BHT are retained. It takes priority over all other events.
- Reset (`rst`=0 at posedge): `pc`=0, valid cleared, BHT=01, queue empty, FSM IDLE. Outputs read as `inst_ID_flag`=0; `inst_MC_req`=0 once FSM is IDLE and no miss is being issued; `inst_ID`/`inst_pc`/`inst_prd_pc` are don't-care while the flag is 0 but driven 0 after reset.

## Timing
- Hit path: word at pc in cycle N appears at the queue head (`inst_ID_flag`=1) in cycle N+1 if the queue was empty. One instruction per cycle sustained on hits.
- Miss path: request in cycle N; response in cycle M; head valid in M+1.
- Outputs `inst_ID*` come combinationally from the queue head registers. `inst_MC_req`/`inst_MC_addr` are combinational from FSM state and pc.
- The redirected PC is fetched in the cycle after `jump_wrong`.

## Test plan
- Reset then hits: preload four NOPs via MC at 0x0–0xC; refetch after `jump_wrong`→0. Required: four consecutive entries with pc 0,4,8,C and prd_pc +4, one per cycle.
- JAL at 0x10 with imm +0x20: required `inst_prd_pc`=0x30; next fetch address 0x30.
- BHT: train `br_upd_pc`=0x40 taken twice; a BEQ at 0x40 with imm −8 must then give prd_pc 0x38. Train not-taken twice; it must give 0x44.
- Full queue: hold `ID_ready`=0. After `2**QLOG` pushes, `inst_MC_req`=0 and pc is frozen. Releasing one pop resumes with no instruction lost or duplicated.
- Flush mid-miss: `jump_wrong`→0x100 while in WAIT. The next `inst_MC_flag` must not fill the cache or enqueue; a new request is issued for 0x100.
- `rdy`=0 for 3 cycles during a hit stream: no push, no pop, pc unchanged.
